// File: rtl/apb_agent_pkg.sv
// Shared APB agent types: transfer direction, protection attributes and requester FSM states.
package apb_agent_pkg;

   typedef enum logic {
      APB_READ  = 1'b0,
      APB_WRITE = 1'b1
   } apb_write_e;

   typedef logic [2:0] apb_pprot_t;

   typedef enum logic [1:0] {
      REQ_IDLE,
      REQ_SETUP,
      REQ_ACCESS,
      REQ_RESP
   } apb_req_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; flags expiry on the LIMIT-th waiting cycle.
module apb_wait_timer #(
   parameter int unsigned LIMIT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CW'(LIMIT))) begin
         count <= count + 1'b1;
      end
   end

   generate
      if (LIMIT == 0) begin : g_disabled
         assign expired = 1'b0;
      end else begin : g_enabled
         assign expired = (count == CW'(LIMIT - 1));
      end
   endgenerate

endmodule

// File: rtl/apb_cmd_requester.sv
// Single-outstanding command-to-APB requester with an optional ACCESS-phase watchdog.
module apb_cmd_requester
   import apb_agent_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   // command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  apb_write_e            cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_strb,
   input  apb_pprot_t            cmd_prot,
   // response port
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_slverr,
   output logic                  rsp_timeout,
   // APB requester side
   output logic [ADDR_WIDTH-1:0] paddr,
   output apb_pprot_t            pprot,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic [STRB_WIDTH-1:0] pstrb,
   input  logic                  pready,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pslverr
);

   apb_req_state_e state;
   logic           cmd_hs;
   logic           timer_expired;
   logic           access_done;

   assign cmd_hs      = (state == REQ_IDLE) && cmd_valid && cmd_ready;
   assign access_done = (state == REQ_ACCESS) && (pready || timer_expired);

   apb_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (pclk),
      .rst_n   (preset_n),
      .clear   (cmd_hs),
      .enable  ((state == REQ_ACCESS) && !pready),
      .expired (timer_expired)
   );

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state       <= REQ_IDLE;
         cmd_ready   <= 1'b0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         paddr       <= '0;
         pprot       <= '0;
         pwrite      <= 1'b0;
         pwdata      <= '0;
         pstrb       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         unique case (state)
            REQ_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_hs) begin
                  cmd_ready <= 1'b0;
                  psel      <= 1'b1;
                  paddr     <= cmd_addr;
                  pprot     <= cmd_prot;
                  pwrite    <= (cmd_write == APB_WRITE);
                  // reads present all-zero data and strobes on the bus
                  pwdata    <= (cmd_write == APB_WRITE) ? cmd_wdata : '0;
                  pstrb     <= (cmd_write == APB_WRITE) ? cmd_strb : '0;
                  state     <= REQ_SETUP;
               end
            end
            REQ_SETUP: begin
               penable <= 1'b1;
               state   <= REQ_ACCESS;
            end
            REQ_ACCESS: begin
               if (access_done) begin
                  if (pready) begin
                     rsp_rdata   <= pwrite ? '0 : prdata;
                     rsp_slverr  <= pslverr;
                     rsp_timeout <= 1'b0;
                  end else begin
                     // watchdog abort: psel drops without a completer handshake
                     rsp_rdata   <= '0;
                     rsp_slverr  <= 1'b1;
                     rsp_timeout <= 1'b1;
                  end
                  rsp_valid <= 1'b1;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  paddr     <= '0;
                  pprot     <= '0;
                  pwrite    <= 1'b0;
                  pwdata    <= '0;
                  pstrb     <= '0;
                  state     <= REQ_RESP;
               end
            end
            REQ_RESP: begin
               if (rsp_ready) begin
                  rsp_valid   <= 1'b0;
                  rsp_rdata   <= '0;
                  rsp_slverr  <= 1'b0;
                  rsp_timeout <= 1'b0;
                  cmd_ready   <= 1'b1;
                  state       <= REQ_IDLE;
               end
            end
            default: begin
               state <= REQ_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_requester.sv
// Self-checking bench for apb_cmd_requester: directed table, random transfers, reset sequences.
module tb_apb_cmd_requester;
   import apb_agent_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned TO = 4;

   logic          pclk = 1'b0;
   logic          preset_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   apb_write_e    cmd_write;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   apb_pprot_t    cmd_prot;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr;
   logic          rsp_timeout;
   logic [AW-1:0] paddr;
   apb_pprot_t    pprot;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic          pready;
   logic [DW-1:0] prdata;
   logic          pslverr;

   apb_cmd_requester #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .pclk        (pclk),
      .preset_n    (preset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_write   (cmd_write),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .cmd_prot    (cmd_prot),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .paddr       (paddr),
      .pprot       (pprot),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .pready      (pready),
      .prdata      (prdata),
      .pslverr     (pslverr)
   );

   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;      // ACCESS cycles with pready low before the completer answers
      logic [31:0] prdata;
      logic        slverr_in;
      int          rsp_delay;  // cycles rsp_ready is held low once rsp_valid appears
      logic [31:0] exp_rdata;
      logic        exp_slverr;
      logic        exp_timeout;
      int          exp_access; // ACCESS cycles (penable high)
   } vec_t;

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int waits, input logic [31:0] rd,
                               input logic se, input int dly, input logic [31:0] e_rd,
                               input logic e_se, input logic e_to, input int e_acc);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = 3'(addr[6:4]);
      v.waits = waits; v.prdata = rd; v.slverr_in = se; v.rsp_delay = dly;
      v.exp_rdata = e_rd; v.exp_slverr = e_se; v.exp_timeout = e_to; v.exp_access = e_acc;
      return v;
   endfunction

   // Reference: the completer answers after `waits` idle cycles unless the watchdog
   // (TO ACCESS cycles) runs out first.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.waits >= int'(TO)) begin
         r.exp_rdata = 0; r.exp_slverr = 1'b1; r.exp_timeout = 1'b1; r.exp_access = TO;
      end else begin
         r.exp_rdata   = v.wr ? 32'h0 : v.prdata;
         r.exp_slverr  = v.slverr_in;
         r.exp_timeout = 1'b0;
         r.exp_access  = v.waits + 1;
      end
      return r;
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      int cyc = 0, acc = 0, setup_idx = -1, first_acc = -1, rsp_idx = -1, dly = v.rsp_delay;
      logic [31:0] h_rdata = 0;
      logic h_se = 0, h_to = 0;
      bit done = 0, bad_field = 0, bad_hold = 0, bad_idle = 0;
      @(negedge pclk);
      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge pclk);
      check({tag, ".cmd_ready_before"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_addr  = v.addr;
      cmd_write = v.wr ? APB_WRITE : APB_READ;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      cmd_prot  = v.prot;
      @(posedge pclk);
      #1 cmd_valid = 1'b0;
      cmd_wdata = $urandom;
      cmd_addr  = $urandom;
      while (!done && cyc < 60) begin
         @(negedge pclk);
         cyc++;
         pready  = 1'($urandom_range(0, 1));  // must be ignored outside ACCESS
         pslverr = 1'($urandom_range(0, 1));
         prdata  = $urandom;
         if (psel) begin
            if (penable) begin
               acc++;
               if (first_acc < 0) first_acc = cyc;
               pready = (acc > v.waits);
               if (pready) begin
                  prdata  = v.prdata;
                  pslverr = v.slverr_in;
               end
            end else if (setup_idx < 0) begin
               setup_idx = cyc;
            end
            if (paddr !== v.addr || pwrite !== v.wr || pprot !== v.prot ||
                pwdata !== (v.wr ? v.wdata : 32'h0) || pstrb !== (v.wr ? v.strb : 4'h0))
               bad_field = 1;
         end else if (rsp_valid) begin
            if (rsp_idx < 0) begin
               rsp_idx = cyc; h_rdata = rsp_rdata; h_se = rsp_slverr; h_to = rsp_timeout;
            end
            if (rsp_rdata !== h_rdata || rsp_slverr !== h_se || rsp_timeout !== h_to ||
                cmd_ready !== 1'b0 || penable !== 1'b0 || paddr !== 0 || pstrb !== 0 ||
                pwdata !== 0)
               bad_hold = 1;
            if (dly > 0) begin
               dly--;
               rsp_ready = 1'b0;
            end else begin
               rsp_ready = 1'b1;
               done = 1;
            end
         end
      end
      check({tag, ".rsp_seen"}, 32'(done), 32'd1);
      check({tag, ".rsp_rdata"}, h_rdata, v.exp_rdata);
      check({tag, ".rsp_slverr"}, 32'(h_se), 32'(v.exp_slverr));
      check({tag, ".rsp_timeout"}, 32'(h_to), 32'(v.exp_timeout));
      check({tag, ".access_cycles"}, 32'(acc), 32'(v.exp_access));
      check({tag, ".setup_cycle"}, 32'(setup_idx), 32'd1);
      check({tag, ".access_cycle"}, 32'(first_acc), 32'd2);
      check({tag, ".rsp_cycle"}, 32'(rsp_idx), 32'(v.exp_access + 2));
      check({tag, ".apb_fields"}, 32'(bad_field), 32'd0);
      check({tag, ".rsp_held"}, 32'(bad_hold), 32'd0);
      @(negedge pclk);
      rsp_ready = 1'b0;
      pready    = 1'b0;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) bad_idle = 1;
      check({tag, ".back_to_idle"}, 32'(bad_idle), 32'd0);
   endtask

   vec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "bench timed out");
   end

   initial begin
      vec_t v;
      int   w;
      preset_n  = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_write = APB_READ;
      cmd_wdata = '0;
      cmd_strb  = '0;
      cmd_prot  = '0;
      rsp_ready = 1'b0;
      pready    = 1'b0;
      prdata    = '0;
      pslverr   = 1'b0;

      //                 wr    addr        wdata         strb  wts prdata        se  dly  e_rdata       e_se e_to e_acc
      tbl[0] = mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0,  32'h0,         0, 0,  32'h0,         0,   0,   1);
      tbl[1] = mk(1'b0, 32'h20, 32'h0,        4'h0, 3,  32'h12345678,  0, 0,  32'h12345678,  0,   0,   4);
      tbl[2] = mk(1'b0, 32'h30, 32'h0,        4'h0, 0,  32'hCAFE0001,  1, 0,  32'hCAFE0001,  1,   0,   1);
      tbl[3] = mk(1'b0, 32'h40, 32'h0,        4'h0, 50, 32'h0,         0, 0,  32'h0,         1,   1,   4);
      tbl[4] = mk(1'b1, 32'h54, 32'hA5A5_0F0F, 4'h5, 1, 32'hFFFFFFFF,  0, 5,  32'h0,         0,   0,   2);
      tbl[5] = mk(1'b1, 32'h68, 32'h0000_1234, 4'h3, 2, 32'h0,         1, 2,  32'h0,         1,   0,   3);

      // reset state
      #12;
      check("reset.psel", 32'(psel), 32'd0);
      check("reset.penable", 32'(penable), 32'd0);
      check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset.cmd_ready", 32'(cmd_ready), 32'd0);
      check("reset.paddr", paddr, 32'h0);
      check("reset.rsp_rdata", rsp_rdata, 32'h0);
      @(negedge pclk);
      preset_n = 1'b1;
      #1 check("release.cmd_ready_low", 32'(cmd_ready), 32'd0);
      @(negedge pclk);
      check("release.cmd_ready_high", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 24; i++) begin
         w = (i % 6 == 5) ? int'(TO) + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
         v = mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), w, $urandom,
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, 0, 0, 0);
         run_txn(model(v), $sformatf("rnd%0d", i));
      end

      // reset pulse in the middle of ACCESS drops the transfer
      @(negedge pclk);
      cmd_valid = 1'b1;
      cmd_addr  = 32'h7C;
      cmd_write = APB_READ;
      cmd_strb  = 4'h0;
      @(posedge pclk);
      #1 cmd_valid = 1'b0;
      pready = 1'b0;
      for (int i = 0; i < 10 && !(psel && penable); i++) @(negedge pclk);
      @(negedge pclk);
      check("midrst.in_access", 32'(psel && penable), 32'd1);
      #2 preset_n = 1'b0;
      #1;
      check("midrst.psel", 32'(psel), 32'd0);
      check("midrst.penable", 32'(penable), 32'd0);
      check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst.cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge pclk);
      preset_n = 1'b1;
      #1 check("midrst.cmd_ready_low", 32'(cmd_ready), 32'd0);
      @(negedge pclk);
      check("midrst.cmd_ready_high", 32'(cmd_ready), 32'd1);
      check("midrst.no_rsp", 32'(rsp_valid || psel), 32'd0);
      run_txn(tbl[1], "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
